// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - round-robin arbiter for the register file write port
//
// Shares the single register file write port among NREQ writeback sources.
// One requester is granted per cycle. The winner is registered onto we/rd/wd
// on the following cycle. Writes to x0 are granted but never issued.
//
// Ports:
//   clk        system clock, all state on rising edge
//   reset      asynchronous active-high reset
//   req_valid  per-requester write request
//   req_rd     packed destination registers, requester i at [5i+4:5i]
//   req_wd     packed write data, requester i at [XLEN*i+XLEN-1:XLEN*i]
//   req_ready  one-hot grant to the winning requester
//   wb_hold    suppresses any grant this cycle
//   we/rd/wd   registered register file write port
//   grant_id   registered index of the requester whose write is on we/rd/wd
module regfile_wb_arbiter #(
   parameter int NREQ = 3,
   parameter int XLEN = 32,
   localparam int IW = $clog2(NREQ)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req_valid,
   input  logic [5*NREQ-1:0]    req_rd,
   input  logic [XLEN*NREQ-1:0] req_wd,
   output logic [NREQ-1:0]      req_ready,
   input  logic                 wb_hold,
   output logic                 we,
   output logic [4:0]           rd,
   output logic [XLEN-1:0]      wd,
   output logic [IW-1:0]        grant_id
);

   logic [IW-1:0]   ptr;
   logic [IW-1:0]   winner;
   logic [IW-1:0]   next_ptr;
   logic [IW-1:0]   idx;
   logic [IW:0]     sum;
   logic            found;
   logic            handshake;
   logic [4:0]      sel_rd;
   logic [XLEN-1:0] sel_wd;

   // Search ptr, ptr+1, ... modulo NREQ for the first valid requester.
   always_comb begin
      found  = 1'b0;
      winner = '0;
      sum    = '0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         sum = {1'b0, ptr} + (IW+1)'(k);
         if (sum >= (IW+1)'(NREQ)) begin
            sum = sum - (IW+1)'(NREQ);
         end
         idx = sum[IW-1:0];
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   // Constant-index mux avoids a variable part-select on the packed buses.
   always_comb begin
      sel_rd = '0;
      sel_wd = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (winner == IW'(i)) begin
            sel_rd = req_rd[5*i +: 5];
            sel_wd = req_wd[XLEN*i +: XLEN];
         end
      end
   end

   // The reset term keeps grants off while reset is held, even though
   // the state is already cleared.
   always_comb begin
      req_ready = '0;
      if (found && !wb_hold && !reset) begin
         req_ready = NREQ'(1) << winner;
      end
   end

   assign handshake = |req_ready;
   assign next_ptr  = (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr      <= '0;
         we       <= 1'b0;
         rd       <= '0;
         wd       <= '0;
         grant_id <= '0;
      end else begin
         // An x0 write is granted to release the requester, but not issued.
         we <= handshake && (sel_rd != 5'd0);
         if (handshake) begin
            ptr      <= next_ptr;
            rd       <= sel_rd;
            wd       <= sel_wd;
            grant_id <= winner;
         end
      end
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed-vector bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

   logic        clk;
   logic        reset;
   logic [2:0]  req_valid;
   logic [14:0] req_rd;
   logic [95:0] req_wd;
   logic [2:0]  req_ready;
   logic        wb_hold;
   logic        we;
   logic [4:0]  rd;
   logic [31:0] wd;
   logic [1:0]  grant_id;

   int n_vec;
   int n_err;

   logic [31:0] rf [32];

   regfile_wb_arbiter #(.NREQ(3), .XLEN(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_rd    (req_rd),
      .req_wd    (req_wd),
      .req_ready (req_ready),
      .wb_hold   (wb_hold),
      .we        (we),
      .rd        (rd),
      .wd        (wd),
      .grant_id  (grant_id)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file model; writes x0 too, so an issued x0 write is visible.
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = 32'd0;
   end
   always @(posedge clk) begin
      if (we) rf[rd] <= wd;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Called at posedge+1; returns at posedge+3 with reset released.
   task automatic do_reset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [4:0] r, input logic [31:0] d);
      req_rd[5*i +: 5]   = r;
      req_wd[32*i +: 32] = d;
   endtask

   initial begin
      n_vec     = 0;
      n_err     = 0;
      reset     = 1'b1;
      req_valid = '0;
      req_rd    = '0;
      req_wd    = '0;
      wb_hold   = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      req_valid = 3'b111;
      #1;
      check("rst_ready", req_ready, 0);
      check("rst_we", we, 0);
      check("rst_rd", rd, 0);
      check("rst_wd", wd, 0);
      check("rst_gid", grant_id, 0);
      req_valid = 3'b000;
      #1;
      reset = 1'b0;

      // Single request
      set_req(0, 5'd5, 32'hDEADBEEF);
      req_valid = 3'b001;
      #1;
      check("single_ready", req_ready, 3'b001);
      tick();
      req_valid = 3'b000;
      check("single_we", we, 1);
      check("single_rd", rd, 5);
      check("single_wd", wd, 32'hDEADBEEF);
      check("single_gid", grant_id, 0);
      tick();
      check("single_we_pulse", we, 0);
      check("single_rf5", rf[5], 32'hDEADBEEF);

      // Round robin from reset
      do_reset();
      set_req(0, 5'd10, 32'h100);
      set_req(1, 5'd11, 32'h101);
      set_req(2, 5'd12, 32'h102);
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         #1;
         check("rr_ready", req_ready, 3'b001 << (k % 3));
         tick();
         check("rr_we", we, 1);
         check("rr_gid", grant_id, k % 3);
         check("rr_rd", rd, 10 + (k % 3));
      end
      req_valid = 3'b000;
      tick();
      check("rr_we_end", we, 0);

      // x0 write is granted but not issued
      set_req(1, 5'd0, 32'h12345678);
      req_valid = 3'b010;
      #1;
      check("x0_ready", req_ready, 3'b010);
      tick();
      req_valid = 3'b000;
      check("x0_we", we, 0);
      check("x0_gid", grant_id, 1);
      check("x0_wd", wd, 32'h12345678);
      tick();
      check("x0_rf0", rf[0], 0);

      // Hold
      do_reset();
      set_req(1, 5'd3, 32'h33);
      set_req(2, 5'd4, 32'h44);
      req_valid = 3'b110;
      wb_hold   = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1;
         check("hold_ready", req_ready, 0);
         tick();
         check("hold_we", we, 0);
      end
      wb_hold = 1'b0;
      #1;
      check("hold_rel_ready1", req_ready, 3'b010);
      tick();
      req_valid = 3'b100;
      check("hold_rel_gid1", grant_id, 1);
      check("hold_rel_rd1", rd, 3);
      #1;
      check("hold_rel_ready2", req_ready, 3'b100);
      tick();
      req_valid = 3'b000;
      check("hold_rel_gid2", grant_id, 2);
      check("hold_rel_rd2", rd, 4);

      // Pointer wrap
      set_req(2, 5'd6, 32'h66);
      req_valid = 3'b100;
      #1;
      check("wrap_ready2", req_ready, 3'b100);
      tick();
      check("wrap_gid2", grant_id, 2);
      set_req(0, 5'd8, 32'h88);
      set_req(1, 5'd9, 32'h99);
      req_valid = 3'b011;
      #1;
      check("wrap_ready0", req_ready, 3'b001);
      tick();
      check("wrap_gid0", grant_id, 0);
      check("wrap_rd0", rd, 8);
      req_valid = 3'b010;
      #1;
      check("wrap_ready1", req_ready, 3'b010);
      tick();
      req_valid = 3'b000;
      check("wrap_gid1", grant_id, 1);
      check("wrap_rd1", rd, 9);

      // Reset mid-operation
      set_req(0, 5'd7, 32'hA5A5A5A5);
      req_valid = 3'b001;
      #1;
      check("mid_ready", req_ready, 3'b001);
      tick();
      req_valid = 3'b000;
      check("mid_we", we, 1);
      check("mid_rd", rd, 7);
      #1;
      reset = 1'b1;
      #1;
      check("mid_rst_we", we, 0);
      check("mid_rst_rd", rd, 0);
      check("mid_rst_wd", wd, 0);
      check("mid_rst_gid", grant_id, 0);
      req_valid = 3'b111;
      #1;
      check("mid_rst_ready", req_ready, 0);
      tick();
      check("mid_rf7", rf[7], 0);
      #1;
      reset = 1'b0;
      #1;
      check("mid_rel_ready", req_ready, 3'b001);
      tick();
      req_valid = 3'b000;
      check("mid_rel_gid", grant_id, 0);
      check("mid_rel_we", we, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
